// File: rtl/srl_fifo.sv
// Synchronous FIFO whose storage is a pure shift register addressed by occupancy,
// so the array maps onto SRL primitives; first-word-fall-through output.
module srl_fifo #(
    parameter int DEPTH        = 32,
    parameter int WIDTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push, pop;
    logic [AW-1:0]    rd_addr;

    // Flags come from the registered count only, never from the request inputs.
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign almost_full = (count_q >= AFULL_CNT);

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // Oldest word sits at the deepest occupied tap; the index wraps harmlessly when empty.
    assign rd_addr = AW'(count_q - CW'(1));
    assign dout    = mem_q[rd_addr];

    // NOTE: the storage array has no reset; a reset term would block SRL mapping,
    // and stale words are unreachable because count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                mem_q[k] <= mem_q[k-1];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d     = count_q;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
